// File: rtl/ysyx_220053_ifu.sv
// ysyx_220053_ifu: instruction fetch unit holding the PC, one outstanding imem request,
// and a valid/ready hand-off of {instr, pc} to decode with redirect and halt support.
module ysyx_220053_ifu #(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic            halted
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_STOP} state_t;
    state_t state, state_n;
    logic [XLEN-1:0] pc, pc_n, pc_o_n;
    logic [31:0] instr_n;
    logic drop, drop_n, rst_q;
    logic req_fire, discard;
    logic [XLEN-1:0] target;
    // rst_q keeps the request line low for the cycle right after reset
    assign imem_req_valid = (state == S_FETCH) && !rst_q;
    assign inst_valid = state == S_HOLD;
    assign halted = state == S_STOP;
    assign imem_addr = pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign target = {redirect_pc[XLEN-1:2], 2'b00};
    assign discard = redirect_valid || drop;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            drop    <= state == S_WAIT;
            instr_o <= '0;
            pc_o    <= '0;
            rst_q   <= 1'b1;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            drop    <= drop_n;
            instr_o <= instr_n;
            pc_o    <= pc_o_n;
            rst_q   <= 1'b0;
        end
    end
    always_comb begin
        state_n = state;
        pc_n    = pc;
        drop_n  = drop;
        instr_n = instr_o;
        pc_o_n  = pc_o;
        if (halt_req) begin
            state_n = S_STOP;
        end else begin
            case (state)
                S_FETCH: begin
                    pc_n = redirect_valid ? target : pc;
                    if (req_fire) begin
                        state_n = S_WAIT;
                        drop_n  = drop || redirect_valid;
                    end
                end
                S_WAIT: begin
                    pc_n = redirect_valid ? target : pc;
                    if (imem_rsp_valid) begin
                        drop_n  = 1'b0;
                        state_n = discard ? S_FETCH : S_HOLD;
                        instr_n = discard ? instr_o : imem_rsp_data;
                        pc_o_n  = discard ? pc_o : pc;
                    end else begin
                        drop_n = discard;
                    end
                end
                S_HOLD: begin
                    pc_n    = redirect_valid ? target : inst_ready ? pc + XLEN'(PC_STEP) : pc;
                    state_n = (redirect_valid || inst_ready) ? S_FETCH : S_HOLD;
                end
                default: state_n = S_STOP;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// tb_ysyx_220053_ifu: cycle-by-cycle directed vectors for the fetch unit; each record gives
// the inputs for one cycle and the outputs expected from the state held during that cycle.
module tb_ysyx_220053_ifu;
    localparam logic [63:0] B = 64'h8000_0000;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
    typedef struct {
        logic rst, rqr, rsv;
        logic [31:0] rsd;
        logic ir, rdv;
        logic [63:0] rdpc;
        logic hlt;
        logic erv;
        logic [63:0] eaddr;
        logic eiv;
        logic [31:0] einstr;
        logic [63:0] epc;
        logic ehalt, full;
    } vec_t;
    logic clk = 0, rst = 1;
    logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
    logic [63:0] imem_addr, pc_o, redirect_pc = 0;
    logic [31:0] imem_rsp_data = 0, instr_o;
    logic inst_valid, inst_ready = 0, redirect_valid = 0, halt_req = 0, halted;
    int n_vec = 0, n_bad = 0;
    vec_t tv[$];
    always #5 clk = ~clk;
    ysyx_220053_ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instr_o(instr_o), .pc_o(pc_o),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .halted(halted)
    );
    function automatic vec_t vec(input logic r, rqr, rsv, input logic [31:0] rsd, input logic ir, rdv,
                                 input logic [63:0] rdpc, input logic hlt, erv, input logic [63:0] eaddr,
                                 input logic eiv, input logic [31:0] einstr, input logic [63:0] epc,
                                 input logic ehalt, full);
        vec_t t;
        t.rst = r; t.rqr = rqr; t.rsv = rsv; t.rsd = rsd; t.ir = ir; t.rdv = rdv; t.rdpc = rdpc; t.hlt = hlt;
        t.erv = erv; t.eaddr = eaddr; t.eiv = eiv; t.einstr = einstr; t.epc = epc; t.ehalt = ehalt; t.full = full;
        return t;
    endfunction
    task automatic apply(input vec_t t, input string tag, input int idx);
        logic bad;
        @(negedge clk);
        rst = t.rst; imem_req_ready = t.rqr; imem_rsp_valid = t.rsv; imem_rsp_data = t.rsd;
        inst_ready = t.ir; redirect_valid = t.rdv; redirect_pc = t.rdpc; halt_req = t.hlt;
        #1;
        n_vec++;
        bad = (imem_req_valid !== t.erv) || (inst_valid !== t.eiv) || (halted !== t.ehalt)
            || (t.erv && imem_addr !== t.eaddr)
            || ((t.eiv || t.full) && (instr_o !== t.einstr || pc_o !== t.epc));
        if (bad) begin
            n_bad++;
            $display("FAIL %s[%0d]: got rv=%b addr=%h iv=%b instr=%h pc=%h halted=%b; want rv=%b addr=%h iv=%b instr=%h pc=%h halted=%b",
                     tag, idx, imem_req_valid, imem_addr, inst_valid, instr_o, pc_o, halted,
                     t.erv, t.eaddr, t.eiv, t.einstr, t.epc, t.ehalt);
        end
    endtask
    initial begin
        // zero-wait fetch stream and backpressure
        tv.push_back(vec(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,1));
        tv.push_back(vec(0,1,0,0,0,0,0,0, 0,0,0,0,0,0,1));
        tv.push_back(vec(0,1,0,0,0,0,0,0, 1,B,0,0,0,0,0));
        tv.push_back(vec(0,0,1,32'h13,0,0,0,0, 0,0,0,0,0,0,0));
        tv.push_back(vec(0,0,0,0,1,0,0,0, 0,0,1,32'h13,B,0,0));
        tv.push_back(vec(0,1,0,0,0,0,0,0, 1,B+4,0,0,0,0,0));
        tv.push_back(vec(0,0,1,32'h0050_0093,0,0,0,0, 0,0,0,0,0,0,0));
        for (int i = 0; i < 5; i++) tv.push_back(vec(0,1,0,0,0,0,0,0, 0,0,1,32'h0050_0093,B+4,0,0));
        tv.push_back(vec(0,0,0,0,1,0,0,0, 0,0,1,32'h0050_0093,B+4,0,0));
        tv.push_back(vec(0,1,0,0,0,0,0,0, 1,B+8,0,0,0,0,0));
        tv.push_back(vec(0,0,1,32'h0010_0073,0,0,0,0, 0,0,0,0,0,0,0));
        tv.push_back(vec(0,0,0,0,1,0,0,0, 0,0,1,32'h0010_0073,B+8,0,0));
        // redirect in WAIT before the response
        tv.push_back(vec(0,1,0,0,0,0,0,0, 1,B+'hC,0,0,0,0,0));
        tv.push_back(vec(0,0,0,0,0,1,B+'h100,0, 0,0,0,0,0,0,0));
        tv.push_back(vec(0,0,1,32'hdead_beef,0,0,0,0, 0,0,0,0,0,0,0));
        tv.push_back(vec(0,0,0,0,0,0,0,0, 1,B+'h100,0,0,0,0,0));
        tv.push_back(vec(0,1,0,0,0,0,0,0, 1,B+'h100,0,0,0,0,0));
        tv.push_back(vec(0,0,1,32'h1111_1111,0,0,0,0, 0,0,0,0,0,0,0));
        // redirect in HOLD with inst_ready, misaligned target
        tv.push_back(vec(0,0,0,0,1,1,B+'h202,0, 0,0,1,32'h1111_1111,B+'h100,0,0));
        // redirect in FETCH while the old request is accepted
        tv.push_back(vec(0,1,0,0,0,1,B+'h300,0, 1,B+'h200,0,0,0,0,0));
        tv.push_back(vec(0,0,1,32'haaaa_5555,0,0,0,0, 0,0,0,0,0,0,0));
        tv.push_back(vec(0,1,0,0,0,0,0,0, 1,B+'h300,0,0,0,0,0));
        // redirect coinciding with the response, then PC wrap
        tv.push_back(vec(0,0,1,32'hbbbb_bbbb,0,1,TOP,0, 0,0,0,0,0,0,0));
        tv.push_back(vec(0,1,0,0,0,0,0,0, 1,TOP,0,0,0,0,0));
        tv.push_back(vec(0,0,1,32'h2222_2222,0,0,0,0, 0,0,0,0,0,0,0));
        tv.push_back(vec(0,0,0,0,1,0,0,0, 0,0,1,32'h2222_2222,TOP,0,0));
        tv.push_back(vec(0,1,0,0,0,0,0,0, 1,64'h0,0,0,0,0,0));
        // halt in WAIT together with redirect
        tv.push_back(vec(0,0,0,0,0,1,B+'h400,1, 0,0,0,0,0,0,0));
        tv.push_back(vec(0,1,1,32'h3333_3333,1,0,0,0, 0,0,0,0,0,1,0));
        repeat (2) @(posedge clk);
        foreach (tv[i]) apply(tv[i], "tbl", i);
        for (int i = 0; i < 20; i++)
            apply(vec(0, 1'($urandom), 1, $urandom, 1, 1'($urandom), B, 1'($urandom), 0,0,0,0,0,1,0), "stop", i);
        // reset out of STOP, then reset while a response is outstanding
        apply(vec(1,0,0,0,0,0,0,0, 0,0,0,0,0,1,0), "seq", 0);
        apply(vec(0,1,0,0,0,0,0,0, 0,0,0,0,0,0,1), "seq", 1);
        apply(vec(0,1,0,0,0,0,0,0, 1,B,0,0,0,0,0), "seq", 2);
        apply(vec(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0), "seq", 3);
        apply(vec(0,1,1,32'h5555_5555,0,0,0,0, 0,0,0,0,0,0,1), "seq", 4);
        apply(vec(0,1,0,0,0,0,0,0, 1,B,0,0,0,0,0), "seq", 5);
        apply(vec(0,0,1,32'h6666_6666,0,0,0,0, 0,0,0,0,0,0,0), "seq", 6);
        apply(vec(0,1,0,0,0,0,0,0, 1,B,0,0,0,0,0), "seq", 7);
        apply(vec(0,0,1,32'h0000_0093,0,0,0,0, 0,0,0,0,0,0,0), "seq", 8);
        apply(vec(0,0,0,0,0,0,0,0, 0,0,1,32'h0000_0093,B,0,0), "seq", 9);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
